// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions for the data memory stage.
package riscv_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_SIZE   = 32;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_f3_e;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Selects the addressed byte/half of a RAM word and sign- or zero-extends it.
module load_align_ext
  import riscv_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [1:0]            i_off,
  input  logic [2:0]            i_func3,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = '0;
    case (i_func3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LW:   o_data = i_word;
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_stage.sv
// RISC-V MEM stage: byte-lane data RAM, load extension and the MEM/WB register.
// Define MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module data_mem_stage #(
  parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
  parameter int MEM_DEPTH  = 256,
  parameter int REG_COUNT  = riscv_pkg::REG_SIZE
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         memReadIn,
  input  logic                         memWriteIn,
  input  logic                         memtoRegIn,
  input  logic                         regWriteIn,
  input  logic [2:0]                   func3In,
  input  logic [DATA_WIDTH-1:0]        aluResultIn,
  input  logic [DATA_WIDTH-1:0]        storeDataIn,
  input  logic [$clog2(REG_COUNT)-1:0] rdIn,
  output logic                         regWriteOut,
  output logic                         memtoRegOut,
  output logic [$clog2(REG_COUNT)-1:0] rdOut,
  output logic [DATA_WIDTH-1:0]        aluResultOut,
  output logic [DATA_WIDTH-1:0]        loadDataOut,
  output logic                         accessFaultOut
);

  import riscv_pkg::*;

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int RD_W  = $clog2(REG_COUNT);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [IDX_W-1:0]      w_idx;
  logic [1:0]            w_off_raw;
  logic [1:0]            w_off;
  logic                  w_is_h;
  logic                  w_is_w;
  logic                  w_invalid;
  logic                  w_suppress;
  logic                  w_fault;
  logic                  w_we;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_ext;
  logic [DATA_WIDTH-1:0] w_ld_next;
  logic                  w_rw_next;

  logic                  r_regWrite;
  logic                  r_memtoReg;
  logic [RD_W-1:0]       r_rd;
  logic [DATA_WIDTH-1:0] r_alu;
  logic [DATA_WIDTH-1:0] r_load;
  logic                  r_fault;

  assign w_idx     = aluResultIn[IDX_W+1:2];
  assign w_off_raw = aluResultIn[1:0];
  assign w_is_h    = (func3In[1:0] == 2'b01);
  assign w_is_w    = (func3In[1:0] == 2'b10);

  assign w_invalid = (memReadIn & memWriteIn) |
                     (memReadIn & ~load_f3_ok(func3In)) |
                     (memWriteIn & ~store_f3_ok(func3In));

`ifdef MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = (memReadIn | memWriteIn) &
                      ((w_is_h & w_off_raw[0]) | (w_is_w & (w_off_raw != 2'b00)));
  assign w_suppress = w_invalid | w_misalign;
  assign w_fault    = w_suppress;
  assign w_off      = w_off_raw;
`else
  // Without trapping, half/word accesses are silently aligned down.
  assign w_suppress = w_invalid;
  assign w_fault    = 1'b0;
  assign w_off      = w_is_h ? {w_off_raw[1], 1'b0} :
                      w_is_w ? 2'b00 : w_off_raw;
`endif

  assign w_we = memWriteIn & ~stall & ~flush & ~w_suppress;

  always_comb begin
    w_be    = '0;
    w_wdata = '0;
    case (func3In)
      F3_SB: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{storeDataIn[7:0]}};
      end
      F3_SH: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{storeDataIn[15:0]}};
      end
      F3_SW: begin
        w_be    = '1;
        w_wdata = storeDataIn;
      end
      default: ;
    endcase
  end

  // RAM is not reset; a store coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (rstN && w_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign w_rd_word = r_mem[w_idx];

  load_align_ext u_load_align_ext (
    .i_word  (w_rd_word),
    .i_off   (w_off),
    .i_func3 (func3In),
    .o_data  (w_ext)
  );

  assign w_ld_next = (memReadIn & ~w_suppress) ? w_ext : '0;
  assign w_rw_next = regWriteIn & ~w_suppress;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_regWrite <= 1'b0;
      r_memtoReg <= 1'b0;
      r_rd       <= '0;
      r_alu      <= '0;
      r_load     <= '0;
      r_fault    <= 1'b0;
    end else if (flush) begin
      r_regWrite <= 1'b0;
      r_memtoReg <= 1'b0;
      r_rd       <= '0;
      r_alu      <= '0;
      r_load     <= '0;
      r_fault    <= 1'b0;
    end else if (!stall) begin
      r_regWrite <= w_rw_next;
      r_memtoReg <= memtoRegIn;
      r_rd       <= rdIn;
      r_alu      <= aluResultIn;
      r_load     <= w_ld_next;
      r_fault    <= w_fault;
    end
  end

  assign regWriteOut    = r_regWrite;
  assign memtoRegOut    = r_memtoReg;
  assign rdOut          = r_rd;
  assign aluResultOut   = r_alu;
  assign loadDataOut    = r_load;
  assign accessFaultOut = r_fault;

endmodule

// File: tb/tb_data_mem_stage.sv
// Scoreboard bench for data_mem_stage against a byte-addressed reference model.
module tb_data_mem_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic        stall, flush, memReadIn, memWriteIn, memtoRegIn, regWriteIn;
  logic [2:0]  func3In;
  logic [31:0] aluResultIn, storeDataIn;
  logic [4:0]  rdIn;
  logic        regWriteOut, memtoRegOut, accessFaultOut;
  logic [4:0]  rdOut;
  logic [31:0] aluResultOut, loadDataOut;

  always #5 clk = ~clk;

  data_mem_stage #(.DATA_WIDTH(32), .MEM_DEPTH(256), .REG_COUNT(32)) dut (
    .clk(clk), .rstN(rstN), .stall(stall), .flush(flush),
    .memReadIn(memReadIn), .memWriteIn(memWriteIn), .memtoRegIn(memtoRegIn),
    .regWriteIn(regWriteIn), .func3In(func3In), .aluResultIn(aluResultIn),
    .storeDataIn(storeDataIn), .rdIn(rdIn), .regWriteOut(regWriteOut),
    .memtoRegOut(memtoRegOut), .rdOut(rdOut), .aluResultOut(aluResultOut),
    .loadDataOut(loadDataOut), .accessFaultOut(accessFaultOut)
  );

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] ld;
    logic        flt;
  } exp_t;

  exp_t       q[$];
  exp_t       mo;
  logic [7:0] mb [1024];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_bad(input bit rd, input bit wr, input logic [2:0] f3,
                               input logic [31:0] a);
    bit bad;
    bad = 1'b0;
    if (rd && wr) bad = 1'b1;
    if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) bad = 1'b1;
    if (wr && f3 > 3'd2) bad = 1'b1;
`ifdef MISALIGN_TRAP_EN
    if ((rd || wr) && f3[1:0] == 2'd1 && a[0]) bad = 1'b1;
    if ((rd || wr) && f3[1:0] == 2'd2 && a[1:0] != 2'd0) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic int unsigned m_addr(input logic [2:0] f3, input logic [31:0] a);
    int unsigned b;
    b = int'(a[9:0]);
`ifndef MISALIGN_TRAP_EN
    if (f3[1:0] == 2'd1) b = b & ~32'd1;
    if (f3[1:0] == 2'd2) b = b & ~32'd3;
`endif
    return b;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int unsigned b);
    case (f3)
      3'd0:    return {{24{mb[b][7]}}, mb[b]};
      3'd1:    return {{16{mb[b+1][7]}}, mb[b+1], mb[b]};
      3'd2:    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
      3'd4:    return {24'd0, mb[b]};
      3'd5:    return {16'd0, mb[b+1], mb[b]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_store(input logic [2:0] f3, input int unsigned b, input logic [31:0] d);
    mb[b] = d[7:0];
    if (f3 != 3'd0) mb[b+1] = d[15:8];
    if (f3 == 3'd2) begin
      mb[b+2] = d[23:16];
      mb[b+3] = d[31:24];
    end
  endtask

  task automatic pop_check();
    exp_t e;
    e = q.pop_front();
    chk("regWriteOut",    {31'd0, regWriteOut},    {31'd0, e.rw});
    chk("memtoRegOut",    {31'd0, memtoRegOut},    {31'd0, e.m2r});
    chk("rdOut",          {27'd0, rdOut},          {27'd0, e.rd});
    chk("aluResultOut",   aluResultOut,            e.alu);
    chk("loadDataOut",    loadDataOut,             e.ld);
    chk("accessFaultOut", {31'd0, accessFaultOut}, {31'd0, e.flt});
  endtask

  task automatic step(input bit rd, input bit wr, input bit m2r, input bit rw,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                      input logic [4:0] rdi, input bit st = 1'b0, input bit fl = 1'b0);
    bit          bad;
    int unsigned b;
    exp_t        nx;
    memReadIn = rd; memWriteIn = wr; memtoRegIn = m2r; regWriteIn = rw;
    func3In = f3; aluResultIn = a; storeDataIn = sd; rdIn = rdi;
    stall = st; flush = fl;
    bad = m_bad(rd, wr, f3, a);
    b   = m_addr(f3, a);
    nx.rw  = rw && !bad;
    nx.m2r = m2r;
    nx.rd  = rdi;
    nx.alu = a;
    nx.ld  = (rd && !bad) ? m_load(f3, b) : 32'd0;
`ifdef MISALIGN_TRAP_EN
    nx.flt = bad;
`else
    nx.flt = 1'b0;
`endif
    if (fl) mo = '0;
    else if (!st) mo = nx;
    q.push_back(mo);
    if (wr && !bad && !st && !fl) m_store(f3, b, sd);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rw"},  {31'd0, regWriteOut},    32'd0);
    chk({tag, "_m2r"}, {31'd0, memtoRegOut},    32'd0);
    chk({tag, "_rd"},  {27'd0, rdOut},          32'd0);
    chk({tag, "_alu"}, aluResultOut,            32'd0);
    chk({tag, "_ld"},  loadDataOut,             32'd0);
    chk({tag, "_flt"}, {31'd0, accessFaultOut}, 32'd0);
  endtask

  initial begin
    rstN = 1'b0; stall = 1'b0; flush = 1'b0; memReadIn = 1'b0; memWriteIn = 1'b0;
    memtoRegIn = 1'b0; regWriteIn = 1'b0; func3In = 3'd0; aluResultIn = '0;
    storeDataIn = '0; rdIn = '0;
    mo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk) rstN = 1'b1;

    // byte store then sign/zero-extended loads
    step(0, 1, 0, 0, 3'b010, 32'h10, 32'h11223344, 5'd0);
    step(0, 1, 0, 0, 3'b000, 32'h12, 32'hFFFFFFAB, 5'd0);
    step(1, 0, 1, 1, 3'b000, 32'h12, 32'h0, 5'd4);
    chk("lb_sext", loadDataOut, 32'hFFFFFFAB);
    step(1, 0, 1, 1, 3'b100, 32'h12, 32'h0, 5'd4);
    chk("lbu_zext", loadDataOut, 32'h000000AB);
    step(1, 0, 1, 1, 3'b010, 32'h10, 32'h0, 5'd4);
    chk("lw_merged", loadDataOut, 32'h11AB3344);

    // half-word store and loads
    step(0, 1, 0, 0, 3'b001, 32'h22, 32'h12348001, 5'd0);
    step(1, 0, 1, 1, 3'b001, 32'h22, 32'h0, 5'd5);
    chk("lh_sext", loadDataOut, 32'hFFFF8001);
    step(1, 0, 1, 1, 3'b101, 32'h22, 32'h0, 5'd5);
    chk("lhu_zext", loadDataOut, 32'h00008001);

    // misaligned word accesses
    step(1, 0, 1, 1, 3'b010, 32'h13, 32'h0, 5'd6);
`ifdef MISALIGN_TRAP_EN
    chk("mis_fault", {31'd0, accessFaultOut}, 32'd1);
    chk("mis_rw",    {31'd0, regWriteOut},    32'd0);
    chk("mis_ld",    loadDataOut,             32'd0);
`else
    chk("mis_aligned_ld", loadDataOut, 32'h11AB3344);
`endif
    step(0, 1, 0, 0, 3'b010, 32'h13, 32'h99999999, 5'd0);
    step(1, 0, 1, 1, 3'b010, 32'h10, 32'h0, 5'd6);
`ifdef MISALIGN_TRAP_EN
    chk("mis_sw_blocked", loadDataOut, 32'h11AB3344);
`else
    chk("mis_sw_aligned", loadDataOut, 32'h99999999);
`endif

    // invalid load func3 and simultaneous read+write are suppressed
    step(1, 0, 1, 1, 3'b011, 32'h10, 32'h0, 5'd8);
    chk("bad_f3_rw", {31'd0, regWriteOut}, 32'd0);
    chk("bad_f3_ld", loadDataOut, 32'd0);
    step(1, 1, 0, 1, 3'b010, 32'h10, 32'h77777777, 5'd8);
    step(0, 1, 0, 0, 3'b011, 32'h10, 32'h66666666, 5'd0);
    step(1, 0, 1, 1, 3'b010, 32'h10, 32'h0, 5'd8);

    // stall holds and suppresses the store; flush inserts a bubble
    step(0, 1, 0, 0, 3'b010, 32'h40, 32'h0BADF00D, 5'd0);
    step(0, 0, 0, 1, 3'b000, 32'h55, 32'h0, 5'd3);
    step(0, 1, 0, 0, 3'b010, 32'h40, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0);
    chk("stall_hold_rd", {27'd0, rdOut}, 32'd3);
    chk("stall_hold_alu", aluResultOut, 32'h55);
    step(1, 0, 1, 1, 3'b010, 32'h40, 32'h0, 5'd2);
    chk("stall_no_store", loadDataOut, 32'h0BADF00D);
    step(0, 0, 0, 1, 3'b000, 32'h99, 32'h0, 5'd9, 1'b0, 1'b1);
    chk("flush_rw", {31'd0, regWriteOut}, 32'd0);
    chk("flush_rd", {27'd0, rdOut}, 32'd0);
    step(0, 0, 1, 1, 3'b000, 32'hAA, 32'h0, 5'd10, 1'b1, 1'b1);
    step(0, 1, 0, 0, 3'b010, 32'h40, 32'hDEADBEEF, 5'd0);
    step(1, 0, 1, 1, 3'b010, 32'h40, 32'h0, 5'd2);
    chk("sw_after_flush", loadDataOut, 32'hDEADBEEF);

    // address wrap and ALU pass-through
    step(0, 1, 0, 0, 3'b010, 32'h400, 32'h5A5A5A5A, 5'd0);
    step(1, 0, 1, 1, 3'b010, 32'h000, 32'h0, 5'd1);
    chk("wrap_ld", loadDataOut, 32'h5A5A5A5A);
    step(0, 0, 0, 1, 3'b000, 32'h1234, 32'h0, 5'd7);
    chk("alu_rd", {27'd0, rdOut}, 32'd7);
    chk("alu_res", aluResultOut, 32'h1234);
    chk("alu_ld", loadDataOut, 32'd0);

    // asynchronous reset mid-stream with a pending store
    memWriteIn = 1'b1; memReadIn = 1'b0; func3In = 3'b010;
    aluResultIn = 32'h40; storeDataIn = 32'hCAFEBABE; stall = 1'b0; flush = 1'b0;
    rstN = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    @(posedge clk);
    #1;
    memWriteIn = 1'b0;
    @(negedge clk) rstN = 1'b1;
    mo = '0;
    step(1, 0, 1, 1, 3'b010, 32'h40, 32'h0, 5'd2);
    chk("rst_store_dropped", loadDataOut, 32'hDEADBEEF);

    // randomized mix over an initialised window
    for (int i = 0; i < 16; i++)
      step(0, 1, 0, 0, 3'b010, 32'h100 + 32'(4 * i), $urandom, 5'd0);
    for (int i = 0; i < 60; i++) begin
      logic [2:0] f3;
      bit rd, wr;
      f3 = 3'($urandom_range(0, 7));
      rd = ($urandom_range(0, 2) == 0);
      wr = !rd && ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 9) == 0) begin
        rd = 1'b1; wr = 1'b1;
      end
      step(rd, wr, rd, 1'($urandom), f3, 32'h100 + 32'($urandom_range(0, 63)), $urandom,
           5'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
